// File: rtl/note_seq_pkg.sv
// rtl/note_seq_pkg.sv - shared types and constants for the note sequencer
package note_seq_pkg;

    localparam int DEF_STEPS   = 16;
    localparam int DEF_TEMPO_W = 24;

    localparam logic [3:0] NOTE_REST = 4'd0;
    localparam logic [3:0] NOTE_MAX  = 4'd12;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GATE = 2'd1,
        ST_REST = 2'd2
    } seq_state_t;

    // Codes above NOTE_MAX are reserved and play as a rest.
    function automatic logic [3:0] audible_note(input logic [3:0] note);
        return (note > NOTE_MAX) ? NOTE_REST : note;
    endfunction

endpackage

// File: rtl/seq_tempo_timer.sv
// rtl/seq_tempo_timer.sv - per-step tick counter with step-end and gate-end compares
module seq_tempo_timer
    import note_seq_pkg::*;
#(
    parameter int TEMPO_W = DEF_TEMPO_W
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_clear,
    input  logic               i_run,
    input  logic [TEMPO_W-1:0] i_tempo,
    input  logic [TEMPO_W-1:0] i_gate_len,
    output logic               o_terminal,
    output logic               o_gate_end
);

    logic [TEMPO_W-1:0] r_tick;
    logic [TEMPO_W-1:0] w_last_tick;

    // Tempo below 2 is clamped so a step always spans at least two clocks.
    assign w_last_tick = (i_tempo < TEMPO_W'(2)) ? TEMPO_W'(1) : (i_tempo - TEMPO_W'(1));

    // >= rather than == so a tempo lowered mid-step ends the step at once.
    assign o_terminal = (r_tick >= w_last_tick);
    assign o_gate_end = (i_gate_len != '0) && (r_tick == (i_gate_len - TEMPO_W'(1)));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_tick <= '0;
        end else if (i_clear || !i_run || o_terminal) begin
            r_tick <= '0;
        end else begin
            r_tick <= r_tick + TEMPO_W'(1);
        end
    end

endmodule

// File: rtl/note_sequencer.sv
// rtl/note_sequencer.sv - step pattern player driving a tone generator
module note_sequencer
    import note_seq_pkg::*;
#(
    parameter  int STEPS   = DEF_STEPS,
    parameter  int TEMPO_W = DEF_TEMPO_W,
    localparam int STEP_W  = $clog2(STEPS)
) (
    input  logic               iCLK,
    input  logic               iRST_N,
    input  logic               iSTART,
    input  logic               iSTOP,
    input  logic [TEMPO_W-1:0] iTEMPO,
    input  logic [TEMPO_W-1:0] iGATE_LEN,
    input  logic [STEP_W-1:0]  iLAST_STEP,
    input  logic               iWR_EN,
    input  logic [STEP_W-1:0]  iWR_ADDR,
    input  logic [3:0]         iWR_NOTE,
    input  logic [15:0]        iWR_VOL,
    output logic [3:0]         oNOTE,
    output logic [15:0]        oVOLUME,
    output logic [STEP_W-1:0]  oSTEP,
    output logic               oSTEP_STROBE,
    output logic               oRUNNING
);

    seq_state_t        r_state;
    seq_state_t        w_state_nxt;

    logic [3:0]        r_pat_note [STEPS];
    logic [15:0]       r_pat_vol  [STEPS];

    logic [STEP_W-1:0] r_step;
    logic [3:0]        r_hold_note;
    logic [15:0]       r_hold_vol;
    logic [15:0]       r_vol_last;
    logic              r_strobe;
    logic              r_running;

    logic              w_start;
    logic              w_advance;
    logic              w_load;
    logic              w_terminal;
    logic              w_gate_end;
    logic              w_bypass;
    logic [STEP_W-1:0] w_next_step;
    logic [STEP_W-1:0] w_load_addr;
    logic [3:0]        w_load_note;
    logic [15:0]       w_load_vol;

    // Stop dominates start; a step load happens on start or at step end.
    assign w_start   = iSTART && !iSTOP;
    assign w_advance = (r_state != ST_IDLE) && w_terminal && !iSTOP && !iSTART;
    assign w_load    = w_start || w_advance;

    // >= also wraps when iLAST_STEP has been lowered below the current step.
    assign w_next_step = ((r_step >= iLAST_STEP) || (r_step == STEP_W'(STEPS - 1)))
                         ? '0 : (r_step + STEP_W'(1));
    assign w_load_addr = w_start ? '0 : w_next_step;

    // A write landing on the entry being loaded this edge is forwarded.
    assign w_bypass    = iWR_EN && (iWR_ADDR == w_load_addr);
    assign w_load_note = w_bypass ? iWR_NOTE : r_pat_note[w_load_addr];
    assign w_load_vol  = w_bypass ? iWR_VOL  : r_pat_vol[w_load_addr];

    seq_tempo_timer #(
        .TEMPO_W (TEMPO_W)
    ) u_timer (
        .i_clk      (iCLK),
        .i_rst_n    (iRST_N),
        .i_clear    (iSTART || iSTOP),
        .i_run      (r_state != ST_IDLE),
        .i_tempo    (iTEMPO),
        .i_gate_len (iGATE_LEN),
        .o_terminal (w_terminal),
        .o_gate_end (w_gate_end)
    );

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            for (int i = 0; i < STEPS; i++) begin
                r_pat_note[i] <= '0;
                r_pat_vol[i]  <= '0;
            end
        end else if (iWR_EN) begin
            r_pat_note[iWR_ADDR] <= iWR_NOTE;
            r_pat_vol[iWR_ADDR]  <= iWR_VOL;
        end
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A zero gate length starts the step already in REST.
    always_comb begin
        w_state_nxt = r_state;
        if (iSTOP) begin
            w_state_nxt = ST_IDLE;
        end else if (w_load) begin
            w_state_nxt = (iGATE_LEN == '0) ? ST_REST : ST_GATE;
        end else begin
            case (r_state)
                ST_GATE: if (w_gate_end) w_state_nxt = ST_REST;
                default: w_state_nxt = r_state;
            endcase
        end
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_step      <= '0;
            r_hold_note <= '0;
            r_hold_vol  <= '0;
            r_vol_last  <= '0;
            r_strobe    <= 1'b0;
            r_running   <= 1'b0;
        end else begin
            r_strobe <= w_load;
            if (iSTOP) begin
                r_running <= 1'b0;
            end else if (w_start) begin
                r_running <= 1'b1;
            end
            if (w_load) begin
                r_step      <= w_load_addr;
                r_hold_note <= w_load_note;
                r_hold_vol  <= w_load_vol;
            end
            if (r_state == ST_GATE) begin
                r_vol_last <= r_hold_vol;
            end
        end
    end

    // Volume outside GATE keeps whatever was last sounding.
    always_comb begin
        oNOTE   = NOTE_REST;
        oVOLUME = r_vol_last;
        if (r_state == ST_GATE) begin
            oNOTE   = audible_note(r_hold_note);
            oVOLUME = r_hold_vol;
        end
    end

    assign oSTEP        = r_step;
    assign oSTEP_STROBE = r_strobe;
    assign oRUNNING     = r_running;

endmodule

// File: tb/tb_note_sequencer.sv
// tb/tb_note_sequencer.sv - self-checking bench for note_sequencer
module tb_note_sequencer;

    localparam int STEPS   = 16;
    localparam int TEMPO_W = 24;
    localparam int STEP_W  = 4;

    logic               iCLK = 1'b0;
    logic               iRST_N = 1'b0;
    logic               iSTART = 1'b0;
    logic               iSTOP = 1'b0;
    logic [TEMPO_W-1:0] iTEMPO = '0;
    logic [TEMPO_W-1:0] iGATE_LEN = '0;
    logic [STEP_W-1:0]  iLAST_STEP = '0;
    logic               iWR_EN = 1'b0;
    logic [STEP_W-1:0]  iWR_ADDR = '0;
    logic [3:0]         iWR_NOTE = '0;
    logic [15:0]        iWR_VOL = '0;
    logic [3:0]         oNOTE;
    logic [15:0]        oVOLUME;
    logic [STEP_W-1:0]  oSTEP;
    logic               oSTEP_STROBE;
    logic               oRUNNING;

    note_sequencer #(.STEPS(STEPS), .TEMPO_W(TEMPO_W)) dut (
        .iCLK(iCLK), .iRST_N(iRST_N), .iSTART(iSTART), .iSTOP(iSTOP),
        .iTEMPO(iTEMPO), .iGATE_LEN(iGATE_LEN), .iLAST_STEP(iLAST_STEP),
        .iWR_EN(iWR_EN), .iWR_ADDR(iWR_ADDR), .iWR_NOTE(iWR_NOTE), .iWR_VOL(iWR_VOL),
        .oNOTE(oNOTE), .oVOLUME(oVOLUME), .oSTEP(oSTEP),
        .oSTEP_STROBE(oSTEP_STROBE), .oRUNNING(oRUNNING)
    );

    always #5 iCLK = ~iCLK;

    int n_checks = 0;
    int n_errors = 0;

    // Reference: a pattern table plus "which step, how many clocks into it".
    int  m_note [STEPS];
    int  m_vol  [STEPS];
    bit  m_run;
    int  m_step, m_age, m_hold_n, m_hold_v, m_lastvol;

    logic [3:0]        e_note;
    logic [15:0]       e_vol;
    logic [STEP_W-1:0] e_step;
    logic              e_stb, e_run;
    logic [25:0]       w_got, w_exp;

    assign w_got = {oNOTE, oVOLUME, oSTEP, oSTEP_STROBE, oRUNNING};
    assign w_exp = {e_note, e_vol, e_step, e_stb, e_run};

    task automatic model_reset();
        for (int i = 0; i < STEPS; i++) begin
            m_note[i] = 0;
            m_vol[i]  = 0;
        end
        m_run = 0; m_step = 0; m_age = 0; m_hold_n = 0; m_hold_v = 0; m_lastvol = 0;
        e_note = '0; e_vol = '0; e_step = '0; e_stb = 1'b0; e_run = 1'b0;
    endtask

    task automatic load_hold(input int a);
        if (iWR_EN && int'(iWR_ADDR) == a) begin
            m_hold_n = int'(iWR_NOTE);
            m_hold_v = int'(iWR_VOL);
        end else begin
            m_hold_n = m_note[a];
            m_hold_v = m_vol[a];
        end
    endtask

    // Advance one clock; the model consumes the inputs present at the edge.
    task automatic clk_step();
        int  t, nxt;
        bit  snd;
        @(posedge iCLK);
        t = (iTEMPO < 2) ? 2 : int'(iTEMPO);
        e_stb = 1'b0;
        if (iSTOP) begin
            m_run = 0;
            m_age = 0;
        end else if (iSTART) begin
            m_run = 1; m_step = 0; m_age = 0;
            load_hold(0);
            e_stb = 1'b1;
        end else if (m_run) begin
            if (m_age >= t - 1) begin
                nxt = (m_step >= int'(iLAST_STEP) || m_step == STEPS - 1) ? 0 : m_step + 1;
                m_step = nxt; m_age = 0;
                load_hold(nxt);
                e_stb = 1'b1;
            end else begin
                m_age++;
            end
        end
        if (iWR_EN) begin
            m_note[iWR_ADDR] = int'(iWR_NOTE);
            m_vol[iWR_ADDR]  = int'(iWR_VOL);
        end
        snd = m_run && (m_age < int'(iGATE_LEN));
        if (snd) m_lastvol = m_hold_v;
        e_note = (snd && m_hold_n <= 12) ? 4'(m_hold_n) : 4'd0;
        e_vol  = 16'(m_lastvol);
        e_step = STEP_W'(m_step);
        e_run  = m_run;
        @(negedge iCLK);
    endtask

    task automatic restart();
        iSTOP = 1'b1;
        clk_step();
        iSTOP = 1'b0;
        iSTART = 1'b1;
        clk_step();
        iSTART = 1'b0;
    endtask

    task automatic test_reset();
        n_checks++;
        if (w_got !== '0) begin
            n_errors++;
            $display("FAIL reset_hold: got %h expected 0", w_got);
        end
        @(negedge iCLK);
        iRST_N = 1'b1;
        for (int c = 0; c < 3; c++) begin
            clk_step();
            n_checks++;
            if (w_got !== w_exp) begin
                n_errors++;
                $display("FAIL reset_idle c%0d: got %h expected %h", c, w_got, w_exp);
            end
        end
    endtask

    task automatic test_basic();
        int exp_n [5] = '{1, 4, 7, 0, 1};
        int exp_s [5] = '{0, 1, 2, 3, 0};
        int q_n[$];
        int q_s[$];
        for (int i = 0; i < 4; i++) begin
            iWR_EN = 1'b1; iWR_ADDR = STEP_W'(i); iWR_VOL = 16'h4000;
            iWR_NOTE = (i == 0) ? 4'd1 : (i == 1) ? 4'd4 : (i == 2) ? 4'd7 : 4'd0;
            clk_step();
        end
        iWR_EN = 1'b0;
        iLAST_STEP = 4'd3; iTEMPO = 24'd10; iGATE_LEN = 24'd6;
        iSTART = 1'b1;
        clk_step();
        iSTART = 1'b0;
        for (int c = 0; c < 45; c++) begin
            n_checks++;
            if (w_got !== w_exp) begin
                n_errors++;
                $display("FAIL basic c%0d: got %h expected %h", c, w_got, w_exp);
            end
            if (oSTEP_STROBE) begin
                q_n.push_back(int'(oNOTE));
                q_s.push_back(int'(oSTEP));
            end
            clk_step();
        end
        n_checks++;
        if (q_n.size() != 5) begin
            n_errors++;
            $display("FAIL basic_strobes: got %0d expected 5", q_n.size());
        end else begin
            for (int k = 0; k < 5; k++) begin
                n_checks++;
                if (q_n[k] != exp_n[k] || q_s[k] != exp_s[k]) begin
                    n_errors++;
                    $display("FAIL basic_seq k%0d: got note %0d step %0d expected note %0d step %0d",
                             k, q_n[k], q_s[k], exp_n[k], exp_s[k]);
                end
            end
        end
    endtask

    task automatic test_tempo_gate_edges();
        int strobes, sounding;
        iTEMPO = 24'd0; iGATE_LEN = 24'd1;
        restart();
        strobes = 0;
        for (int c = 0; c < 12; c++) begin
            n_checks++;
            if (w_got !== w_exp) begin
                n_errors++;
                $display("FAIL tempo0 c%0d: got %h expected %h", c, w_got, w_exp);
            end
            strobes += int'(oSTEP_STROBE);
            clk_step();
        end
        n_checks++;
        if (strobes != 6) begin
            n_errors++;
            $display("FAIL tempo0_strobes: got %0d expected 6", strobes);
        end
        for (int g = 0; g < 2; g++) begin
            iTEMPO = 24'd10;
            iGATE_LEN = (g == 0) ? 24'd20 : 24'd0;
            restart();
            sounding = 0;
            strobes = 0;
            for (int c = 0; c < 40; c++) begin
                n_checks++;
                if (w_got !== w_exp) begin
                    n_errors++;
                    $display("FAIL gate%0d c%0d: got %h expected %h", g, c, w_got, w_exp);
                end
                sounding += (oNOTE != 4'd0) ? 1 : 0;
                strobes  += int'(oSTEP_STROBE);
                clk_step();
            end
            n_checks++;
            if (sounding != ((g == 0) ? 30 : 0) || strobes != 4) begin
                n_errors++;
                $display("FAIL gate%0d_totals: got sounding %0d strobes %0d expected %0d and 4",
                         g, sounding, strobes, (g == 0) ? 30 : 0);
            end
        end
    endtask

    task automatic test_bypass();
        bit done_byp = 0, done_far = 0, heard = 0, byp_now, far_now;
        iTEMPO = 24'd10; iGATE_LEN = 24'd6;
        restart();
        for (int c = 0; c < 60; c++) begin
            n_checks++;
            if (w_got !== w_exp) begin
                n_errors++;
                $display("FAIL bypass c%0d: got %h expected %h", c, w_got, w_exp);
            end
            iWR_EN = 1'b0; byp_now = 0; far_now = 0;
            if (m_run && m_step == 1 && m_age == 9 && !done_byp) begin
                iWR_EN = 1'b1; iWR_ADDR = 4'd2; iWR_NOTE = 4'd9; iWR_VOL = 16'h1234;
                byp_now = 1; done_byp = 1;
            end else if (m_run && m_step == 2 && m_age == 2 && !done_far) begin
                iWR_EN = 1'b1; iWR_ADDR = 4'd0; iWR_NOTE = 4'd11; iWR_VOL = 16'h0042;
                far_now = 1; done_far = 1;
            end
            clk_step();
            iWR_EN = 1'b0;
            if (byp_now) begin
                n_checks++;
                if (oNOTE !== 4'd9 || oSTEP !== 4'd2 || oVOLUME !== 16'h1234) begin
                    n_errors++;
                    $display("FAIL bypass_load: got note %0d step %0d vol %h expected 9 2 1234",
                             oNOTE, oSTEP, oVOLUME);
                end
            end
            if (far_now) begin
                n_checks++;
                if (oNOTE !== 4'd9) begin
                    n_errors++;
                    $display("FAIL far_write_now: got note %0d expected 9", oNOTE);
                end
            end
            if (done_far && !heard && oSTEP_STROBE && oSTEP == 4'd0) begin
                heard = 1;
                n_checks++;
                if (oNOTE !== 4'd11) begin
                    n_errors++;
                    $display("FAIL far_write_revisit: got note %0d expected 11", oNOTE);
                end
            end
        end
        n_checks++;
        if (!(done_byp && heard)) begin
            n_errors++;
            $display("FAIL bypass_reached: got %0d%0d expected 11", done_byp, heard);
        end
    endtask

    task automatic test_start_stop();
        bit reached = 0;
        iTEMPO = 24'd10; iGATE_LEN = 24'd6;
        restart();
        repeat (5) clk_step();
        iSTART = 1'b1; iSTOP = 1'b1;
        clk_step();
        iSTART = 1'b0; iSTOP = 1'b0;
        n_checks++;
        if (oRUNNING !== 1'b0 || oNOTE !== 4'd0 || w_got !== w_exp) begin
            n_errors++;
            $display("FAIL start_and_stop: got run %b note %0d expected 0 0", oRUNNING, oNOTE);
        end
        iSTART = 1'b1;
        clk_step();
        iSTART = 1'b0;
        for (int c = 0; c < 40 && !reached; c++) begin
            if (m_step == 2 && m_age == 3) begin
                reached = 1;
            end else begin
                clk_step();
                n_checks++;
                if (w_got !== w_exp) begin
                    n_errors++;
                    $display("FAIL to_step2 c%0d: got %h expected %h", c, w_got, w_exp);
                end
            end
        end
        iSTART = 1'b1;
        clk_step();
        iSTART = 1'b0;
        n_checks++;
        if (!reached || oSTEP !== 4'd0 || oSTEP_STROBE !== 1'b1 || oRUNNING !== 1'b1 || oNOTE !== 4'd11) begin
            n_errors++;
            $display("FAIL restart_mid: got step %0d stb %b run %b note %0d expected 0 1 1 11",
                     oSTEP, oSTEP_STROBE, oRUNNING, oNOTE);
        end
    endtask

    task automatic test_note14();
        iWR_EN = 1'b1; iWR_ADDR = 4'd0; iWR_NOTE = 4'd14; iWR_VOL = 16'h7777;
        clk_step();
        iWR_EN = 1'b0;
        iLAST_STEP = 4'd0; iTEMPO = 24'd4; iGATE_LEN = 24'd3;
        restart();
        for (int c = 0; c < 8; c++) begin
            n_checks++;
            if (oNOTE !== 4'd0 || w_got !== w_exp) begin
                n_errors++;
                $display("FAIL note14 c%0d: got %h expected %h (note 0)", c, w_got, w_exp);
            end
            clk_step();
        end
    endtask

    task automatic test_random();
        for (int seg = 0; seg < 4; seg++) begin
            iTEMPO     = TEMPO_W'($urandom_range(0, 12));
            iGATE_LEN  = TEMPO_W'($urandom_range(0, 14));
            iLAST_STEP = STEP_W'($urandom_range(0, 15));
            restart();
            for (int c = 0; c < 150; c++) begin
                n_checks++;
                if (w_got !== w_exp) begin
                    n_errors++;
                    $display("FAIL random s%0d c%0d: got %h expected %h", seg, c, w_got, w_exp);
                end
                iWR_EN   = ($urandom_range(0, 3) == 0);
                iWR_ADDR = STEP_W'($urandom_range(0, 15));
                iWR_NOTE = 4'($urandom_range(0, 15));
                iWR_VOL  = 16'($urandom);
                iSTART   = ($urandom_range(0, 79) == 0);
                iSTOP    = ($urandom_range(0, 119) == 0);
                if ($urandom_range(0, 49) == 0) iLAST_STEP = STEP_W'($urandom_range(0, 15));
                if ($urandom_range(0, 59) == 0) iTEMPO = TEMPO_W'($urandom_range(0, 12));
                clk_step();
            end
            iWR_EN = 1'b0; iSTART = 1'b0; iSTOP = 1'b0;
        end
    endtask

    task automatic test_async_reset();
        iWR_EN = 1'b1; iWR_ADDR = 4'd0; iWR_NOTE = 4'd5; iWR_VOL = 16'h2222;
        clk_step();
        iWR_EN = 1'b0;
        iLAST_STEP = 4'd0; iTEMPO = 24'd10; iGATE_LEN = 24'd8;
        restart();
        repeat (3) clk_step();
        n_checks++;
        if (oNOTE !== 4'd5 || w_got !== w_exp) begin
            n_errors++;
            $display("FAIL pre_reset: got note %0d expected 5", oNOTE);
        end
        #2 iRST_N = 1'b0;
        #1;
        n_checks++;
        if (w_got !== '0) begin
            n_errors++;
            $display("FAIL async_reset: got %h expected 0", w_got);
        end
        @(posedge iCLK);
        @(negedge iCLK);
        iRST_N = 1'b1;
        model_reset();
        repeat (3) begin
            clk_step();
            n_checks++;
            if (oRUNNING !== 1'b0 || w_got !== w_exp) begin
                n_errors++;
                $display("FAIL post_reset_idle: got %h expected %h", w_got, w_exp);
            end
        end
        iLAST_STEP = 4'd15; iTEMPO = 24'd3; iGATE_LEN = 24'd10;
        restart();
        for (int c = 0; c < 48; c++) begin
            n_checks++;
            if (oNOTE !== 4'd0 || oVOLUME !== 16'd0 || w_got !== w_exp) begin
                n_errors++;
                $display("FAIL cleared_pattern c%0d: got %h expected %h", c, w_got, w_exp);
            end
            clk_step();
        end
    endtask

    initial begin
        model_reset();
        #12;
        test_reset();
        test_basic();
        test_tempo_gate_edges();
        test_bypass();
        test_start_stop();
        test_note14();
        test_random();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/note_sequencer.md
NOTE_SEQUENCER -- requirements
Module: note_sequencer

Interface
REQ-001 SHALL have parameter STEPS, default 16, number of pattern steps (power of 2).
REQ-002 SHALL have parameter TEMPO_W, default 24, width of the tempo and gate counters.
REQ-003 SHALL have port iCLK, input, 1, the single clock; all logic on its rising edge.
REQ-004 SHALL have port iRST_N, input, 1, reset; asynchronous, active-low.
REQ-005 SHALL have port iSTART, input, 1, single-cycle pulse that starts playback.
REQ-006 SHALL have port iSTOP, input, 1, single-cycle pulse that stops playback.
REQ-007 SHALL have port iTEMPO, input, TEMPO_W, clocks per step.
REQ-008 SHALL have port iGATE_LEN, input, TEMPO_W, clocks per step that the note sounds.
REQ-009 SHALL have port iLAST_STEP, input, log2(STEPS), index of the final step before wrap.
REQ-010 SHALL have port iWR_EN, input, 1, pattern write strobe.
REQ-011 SHALL have port iWR_ADDR, input, log2(STEPS), pattern write address.
REQ-012 SHALL have port iWR_NOTE, input, 4, note code to store.
REQ-013 SHALL have port iWR_VOL, input, 16, volume to store.
REQ-014 SHALL have port oNOTE, output, 4, note code to the tone generator; 0 means silence.
REQ-015 SHALL have port oVOLUME, output, 16, volume to the tone generator.
REQ-016 SHALL have port oSTEP, output, log2(STEPS), current step index.
REQ-017 SHALL have port oSTEP_STROBE, output, 1, one-cycle pulse at each step start.
REQ-018 SHALL have port oRUNNING, output, 1, high while playing.

Function
REQ-019 Pattern SHALL be STEPS entries of {note[3:0], vol[15:0]}; iWR_EN SHALL write the entry at iWR_ADDR on the next edge, in any state.
REQ-020 The FSM SHALL have states IDLE, GATE and REST.
REQ-021 iSTART in any state SHALL load step 0, enter GATE, zero the tick counter, and on the following edge set oRUNNING=1, oSTEP=0 and oSTEP_STROBE=1 (latency 1 cycle).
REQ-022 iSTOP SHALL go to IDLE with oNOTE=0 and oRUNNING=0 on the next edge; iSTOP SHALL win when it coincides with iSTART.
REQ-023 The tick counter SHALL count 0..T-1, where T = max(iTEMPO, 2); at T-1 the step SHALL advance, the counter SHALL return to 0, and oSTEP_STROBE SHALL pulse.
REQ-024 Step advance SHALL be oSTEP+1, wrapping to 0 after oSTEP==iLAST_STEP or after STEPS-1; if iLAST_STEP is lowered below oSTEP, the next advance SHALL wrap to 0.
REQ-025 The entry SHALL be latched into hold registers at step start; a write to the step being loaded in the same cycle SHALL be bypassed, with the new data used.
REQ-026 In GATE, oNOTE SHALL equal the held note and oVOLUME the held volume; the FSM SHALL move to REST when tick == iGATE_LEN-1.
REQ-027 iGATE_LEN >= T SHALL sound the full step (legato); iGATE_LEN == 0 SHALL enter REST directly (silent step).
REQ-028 In REST and IDLE, oNOTE SHALL be 0; oVOLUME SHALL keep its last value.
REQ-029 Held note codes 13..15 SHALL output as 0 (rest).
REQ-030 iTEMPO and iGATE_LEN changes SHALL take effect on the next compare; no step SHALL ever exceed the new T.

Reset
REQ-031 While iRST_N=0: FSM SHALL be IDLE; oNOTE=0, oVOLUME=0, oSTEP=0, oSTEP_STROBE=0, oRUNNING=0; tick counter=0; all pattern entries=0.
REQ-032 Reset asserted mid-play SHALL silence outputs immediately (asynchronously); after release the block SHALL stay in IDLE until iSTART.

Structure
REQ-033 Package note_seq_pkg SHALL hold the state enum, NOTE_REST=0, NOTE_MAX=12 and the default STEPS and TEMPO_W.
REQ-034 The tick counter and terminal-count compare SHALL be sub-module seq_tempo_timer.

Verification
REQ-035 Write steps 0..3 with notes 1,4,7,0 at vol 16'h4000; iLAST_STEP=3, iTEMPO=10, iGATE_LEN=6; pulse iSTART -> oNOTE sequence 1,4,7,0 repeating, each held 6 of 10 cycles, strobe every 10 cycles, oSTEP wraps 3->0.
REQ-036 iTEMPO=0 -> steps last 2 cycles; iGATE_LEN=20 with iTEMPO=10 -> oNOTE continuous across steps; iGATE_LEN=0 -> oNOTE stays 0.
REQ-037 Same-cycle write to the next step at its load edge (note 9) -> step plays 9; write to a non-current step -> heard only on its next visit.
REQ-038 iSTART and iSTOP together -> IDLE, oRUNNING=0; iSTART mid-step 2 -> oSTEP=0 one cycle later.
REQ-039 Stored note 14 -> oNOTE=0 for that step; iRST_N low mid-GATE -> all outputs 0 within the same cycle; pattern reads 0 after release.
